key_debounce: RTL and testbench

//  Conditions the raw active-low DE2-115 KEY pushbuttons into clean, glitch-free control signals.

---
 rtl/key_debounce_pkg.sv | 15 +
 rtl/key_debounce_core.sv | 143 ++++++++++++++
 rtl/key_debounce.sv | 36 +++
 tb/tb_key_debounce.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and default constants for the pushbutton debouncer.
// Defines the per-key FSM state encoding and 50 MHz timing defaults.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_WAIT,
    S_HELD,
    S_REL_WAIT
  } key_state_e;

  localparam int DEB_CNT_50MHZ  = 500000;
  localparam int LONG_CNT_50MHZ = 50000000;

endpackage

// File: rtl/key_debounce_core.sv
// One debounce channel: 2-FF sync, debounce FSM, counters, pulses.
// Ports: i_clk, i_rst_n, i_key_n (raw, active-low) in;
//   o_pressed, o_press_pulse, o_release_pulse, o_long_pulse out.
// Macro KEY_DEBOUNCE_LONGPRESS_EN enables the long-press counter.
module key_debounce_core
  import key_debounce_pkg::*;
#(
  parameter int CNT_N  = DEB_CNT_50MHZ,
  parameter int LONG_N = LONG_CNT_50MHZ
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  output logic o_pressed,
  output logic o_press_pulse,
  output logic o_release_pulse,
  output logic o_long_pulse
);

  localparam int CW = $clog2(CNT_N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CNT_N - 1);

  logic          r_sync1;
  logic          r_sync2;
  key_state_e    r_state;
  key_state_e    w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_done;
  logic          w_pressed;
  logic          w_press_p;
  logic          w_rel_p;

  // >= also covers CNT_N==1: the wait completes on its first cycle
  assign w_done = (r_cnt >= C_LAST);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      r_state         <= S_IDLE;
      r_cnt           <= '0;
      o_pressed       <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
    end else begin
      r_sync1         <= i_key_n;
      r_sync2         <= r_sync1;
      r_state         <= w_next;
      r_cnt           <= w_cnt_nxt;
      o_pressed       <= w_pressed;
      o_press_pulse   <= w_press_p;
      o_release_pulse <= w_rel_p;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (!r_sync2) begin
          w_next    = S_PRESS_WAIT;
          w_cnt_nxt = CW'(1);
        end
      end
      S_PRESS_WAIT: begin
        if (r_sync2) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else if (w_done) begin
          w_next    = S_HELD;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_HELD: begin
        if (r_sync2) begin
          w_next    = S_REL_WAIT;
          w_cnt_nxt = CW'(1);
        end
      end
      S_REL_WAIT: begin
        if (!r_sync2) begin
          w_next    = S_HELD;
          w_cnt_nxt = '0;
        end else if (w_done) begin
          w_next    = S_IDLE;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_next    = S_IDLE;
        w_cnt_nxt = '0;
      end
    endcase
  end

  // outputs are decoded from the transition and registered
  always_comb begin
    w_pressed = (w_next == S_HELD) || (w_next == S_REL_WAIT);
    w_press_p = (r_state == S_PRESS_WAIT) && (w_next == S_HELD);
    w_rel_p   = (r_state == S_REL_WAIT) && (w_next == S_IDLE);
  end

`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam int LW = $clog2(LONG_N + 1);
  localparam logic [LW-1:0] L_MAX  = LW'(LONG_N);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_N - 1);

  logic [LW-1:0] r_long_cnt;
  logic          r_long;
  logic          w_in_held;

  assign w_in_held = (r_state == S_HELD) || (r_state == S_REL_WAIT);

  // saturates at LONG_N so the pulse cannot repeat within one press
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_long_cnt <= '0;
      r_long     <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!w_in_held) begin
        r_long_cnt <= '0;
      end else if (r_long_cnt != L_MAX) begin
        r_long_cnt <= r_long_cnt + LW'(1);
        r_long     <= (r_long_cnt == L_LAST);
      end
    end
  end

  assign o_long_pulse = r_long;
`else
  assign o_long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS raw active-low pushbuttons, one core per key.
// Ports: i_clk, i_rst_n, i_key_n[NUM_KEYS] in; o_pressed, o_press_pulse,
//   o_release_pulse, o_long_pulse [NUM_KEYS] out.
// Macro KEY_DEBOUNCE_LONGPRESS_EN enables o_long_pulse.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS = 4,
  parameter int CNT_N    = DEB_CNT_50MHZ,
  parameter int LONG_N   = LONG_CNT_50MHZ
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_key_n,
  output logic [NUM_KEYS-1:0] o_pressed,
  output logic [NUM_KEYS-1:0] o_press_pulse,
  output logic [NUM_KEYS-1:0] o_release_pulse,
  output logic [NUM_KEYS-1:0] o_long_pulse
);

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce_core #(
      .CNT_N (CNT_N),
      .LONG_N(LONG_N)
    ) u_core (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_key_n        (i_key_n[g]),
      .o_pressed      (o_pressed[g]),
      .o_press_pulse  (o_press_pulse[g]),
      .o_release_pulse(o_release_pulse[g]),
      .o_long_pulse   (o_long_pulse[g])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce (CNT_N=4, LONG_N=20, 4 keys).
// Directed scenarios plus random bouncing against a run-length model.
module tb_key_debounce;

  localparam int NK     = 4;
  localparam int CNT_N  = 4;
  localparam int LONG_N = 20;
`ifdef KEY_DEBOUNCE_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [NK-1:0] i_key_n = '1;
  logic [NK-1:0] o_pressed;
  logic [NK-1:0] o_press_pulse;
  logic [NK-1:0] o_release_pulse;
  logic [NK-1:0] o_long_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  key_debounce #(
    .NUM_KEYS(NK),
    .CNT_N   (CNT_N),
    .LONG_N  (LONG_N)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_key_n        (i_key_n),
    .o_pressed      (o_pressed),
    .o_press_pulse  (o_press_pulse),
    .o_release_pulse(o_release_pulse),
    .o_long_pulse   (o_long_pulse)
  );

  always #5 i_clk = ~i_clk;

  // Model: the key reaches the logic two edges late; a new level is
  // accepted after CNT_N consecutive samples differing from the current
  // one. Long press fires LONG_N cycles after acceptance of a press.
  logic [NK-1:0] m_d1, m_d2, m_lvl, m_pp, m_rp, m_lp;
  int m_run [NK];
  int m_hold[NK];

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_d1  <= '1;
      m_d2  <= '1;
      m_lvl <= '0;
      m_pp  <= '0;
      m_rp  <= '0;
      m_lp  <= '0;
      for (int k = 0; k < NK; k++) begin
        m_run[k]  <= 0;
        m_hold[k] <= 0;
      end
    end else begin
      m_d1 <= i_key_n;
      m_d2 <= m_d1;
      for (int k = 0; k < NK; k++) begin
        m_pp[k] <= 1'b0;
        m_rp[k] <= 1'b0;
        m_lp[k] <= 1'b0;
        if (m_lvl[k]) begin
          if (m_hold[k] < LONG_N) m_hold[k] <= m_hold[k] + 1;
          if (m_hold[k] == LONG_N - 1) m_lp[k] <= LONG_EN;
        end else begin
          m_hold[k] <= 0;
        end
        if (!m_d2[k] != m_lvl[k]) begin
          if (m_run[k] + 1 >= CNT_N) begin
            m_lvl[k] <= !m_d2[k];
            m_run[k] <= 0;
            if (!m_d2[k]) m_pp[k] <= 1'b1;
            else m_rp[k] <= 1'b1;
          end else begin
            m_run[k] <= m_run[k] + 1;
          end
        end else begin
          m_run[k] <= 0;
        end
      end
    end
  end

  task automatic chk();
    n_cmp++;
    assert (o_pressed === m_lvl) else begin
      n_bad++;
      $error("FAIL pressed obs=%b exp=%b", o_pressed, m_lvl);
    end
    n_cmp++;
    assert (o_press_pulse === m_pp) else begin
      n_bad++;
      $error("FAIL press_pulse obs=%b exp=%b", o_press_pulse, m_pp);
    end
    n_cmp++;
    assert (o_release_pulse === m_rp) else begin
      n_bad++;
      $error("FAIL rel_pulse obs=%b exp=%b", o_release_pulse, m_rp);
    end
    n_cmp++;
    assert (o_long_pulse === m_lp) else begin
      n_bad++;
      $error("FAIL long_pulse obs=%b exp=%b", o_long_pulse, m_lp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
    chk();
  endtask

  task automatic expect_int(string tag, int obs, int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cnt;
    int dur[NK];

    // 1: reset held, keys toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      i_key_n = 4'($urandom);
      #1;
      expect_int("rst_outs", int'({o_pressed, o_press_pulse,
                 o_release_pulse, o_long_pulse}), 0);
    end
    @(negedge i_clk);
    i_key_n = '1;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (6) cyc();

    // 2: key0 press, pulse after edge 5
    i_key_n[0] = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      expect_int("k0_pp", int'(o_press_pulse[0]), int'(i == 6));
      expect_int("k0_lvl", int'(o_pressed[0]), int'(i >= 6));
    end
    expect_int("k123_idle", int'(o_pressed[3:1]), 0);

    // 3: key1 bounce then steady
    cnt = 0;
    i_key_n[1] = 1'b0;
    repeat (3) begin cyc(); cnt += int'(o_press_pulse[1]); end
    i_key_n[1] = 1'b1;
    cyc(); cnt += int'(o_press_pulse[1]);
    i_key_n[1] = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      cnt += int'(o_press_pulse[1]);
      if (i == 6) expect_int("k1_pp_at6", int'(o_press_pulse[1]), 1);
    end
    expect_int("k1_pp_cnt", cnt, 1);
    // isolated 3-cycle glitch on key2
    cnt = 0;
    i_key_n[2] = 1'b0;
    repeat (3) begin cyc(); cnt += int'(o_press_pulse[2]); end
    i_key_n[2] = 1'b1;
    repeat (10) begin cyc(); cnt += int'(o_press_pulse[2]); end
    expect_int("k2_glitch", cnt, 0);

    // 4: key0 release
    i_key_n[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      expect_int("k0_rp", int'(o_release_pulse[0]), int'(i == 6));
      expect_int("k0_fall", int'(o_pressed[0]), int'(i < 6));
    end
    i_key_n[1] = 1'b1;
    repeat (8) cyc();

    // 5: long press on key2
    cnt = 0;
    i_key_n[2] = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      cyc();
      cnt += int'(o_long_pulse[2]);
      if (LONG_EN && i == 26)
        expect_int("k2_long_at", int'(o_long_pulse[2]), 1);
    end
    expect_int("k2_long_cnt", cnt, LONG_EN ? 1 : 0);
    i_key_n[2] = 1'b1;
    repeat (8) cyc();

    // random bouncing on all keys
    for (int k = 0; k < NK; k++) dur[k] = 1;
    for (int c = 0; c < 500; c++) begin
      for (int k = 0; k < NK; k++) begin
        dur[k]--;
        if (dur[k] <= 0) begin
          i_key_n[k] = ~i_key_n[k];
          dur[k] = ($urandom_range(0, 1) != 0)
                 ? int'($urandom_range(1, 5))
                 : int'($urandom_range(6, 30));
        end
      end
      cyc();
    end
    i_key_n = '1;
    repeat (10) cyc();

    // 6: async reset while key3 held
    i_key_n[3] = 1'b0;
    repeat (10) cyc();
    expect_int("k3_held", int'(o_pressed[3]), 1);
    #2 i_rst_n = 1'b0;
    #1;
    expect_int("k3_async", int'(o_pressed), 0);
    repeat (3) cyc();
    i_rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      expect_int("k3_repress", int'(o_press_pulse[3]), int'(i == 6));
    end
    i_key_n = '1;
    repeat (10) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
